// File: rtl/pmc_ac_pkg.sv
// Shared types and constants for the PMC analog-configuration serial loader.
// Used by pmc_ac_ctrl and pmc_ac_sclk_gen.
package pmc_ac_pkg;

   localparam int PMC_AC_BITS  = 128;
   localparam int PMC_AC_CNT_W = $clog2(PMC_AC_BITS);

   // reg_0 occupies the top word, so reg_0[31] is the first bit on the chain
   typedef struct packed {
      logic [31:0] reg_0;
      logic [31:0] reg_1;
      logic [31:0] reg_2;
      logic [31:0] reg_3;
   } pmc_ac_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2,
      DONE  = 2'd3
   } pmc_ac_ctrl_state_t;

endpackage

// File: rtl/pmc_ac_sclk_gen.sv
// Serial-clock generator: each bit is CLK_DIV low cycles followed by CLK_DIV high cycles.
// The rise tick output exists only when PMC_AC_READBACK_EN is defined.
module pmc_ac_sclk_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_sclk,
   output logic o_bitEnd
`ifdef PMC_AC_READBACK_EN
   ,
   output logic o_rise
`endif
);

   localparam logic [8:0] HALF = 9'(CLK_DIV);
   localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);

   logic [8:0] r_phase;
   logic [8:0] w_phaseNext;
   logic       r_sclk;

   // Phase sits at zero whenever disabled, so each sequence starts on a fresh low phase
   always_comb begin
      w_phaseNext = '0;
      if (i_en && (r_phase != LAST)) begin
         w_phaseNext = r_phase + 9'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase <= '0;
         r_sclk  <= 1'b0;
      end else begin
         r_phase <= w_phaseNext;
         r_sclk  <= i_en && (w_phaseNext >= HALF);
      end
   end

   assign o_sclk   = r_sclk;
   assign o_bitEnd = i_en && (r_phase == LAST);

`ifdef PMC_AC_READBACK_EN
   assign o_rise = i_en && (r_phase == HALF);
`endif

endmodule

// File: rtl/pmc_ac_ctrl.sv
// Serial loader: snapshots the analog-config register set and shifts it MSB first into the
// matrix chain, then strobes the latch. Define PMC_AC_READBACK_EN for previous-contents readback.
module pmc_ac_ctrl
   import pmc_ac_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic    i_clk,
   input  logic    i_rst_n,
   input  logic    i_start,
   input  pmc_ac_t i_ac,
   output logic    o_busy,
   output logic    o_done,
   output logic    o_ac_sclk,
   output logic    o_ac_sdo,
   output logic    o_ac_latch
`ifdef PMC_AC_READBACK_EN
   ,
   input  logic    i_ac_sdi,
   output pmc_ac_t o_rdbk,
   output logic    o_rdbk_valid
`endif
);

   localparam logic [PMC_AC_CNT_W-1:0] BIT_LAST   = PMC_AC_CNT_W'(PMC_AC_BITS - 1);
   localparam logic [7:0]              LATCH_LAST = 8'(CLK_DIV - 1);

   pmc_ac_ctrl_state_t r_state;
   pmc_ac_ctrl_state_t w_stateNext;

   logic [PMC_AC_BITS-1:0]  r_shift;
   logic [PMC_AC_BITS-1:0]  w_shiftNext;
   logic [PMC_AC_CNT_W-1:0] r_bitCnt;
   logic [PMC_AC_CNT_W-1:0] w_bitCntNext;
   logic [7:0]              r_latchCnt;
   logic [7:0]              w_latchCntNext;
   logic                    r_sdo;
   logic                    w_sdoNext;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_latch;

   logic w_shiftEn;
   logic w_sclk;
   logic w_bitEnd;
`ifdef PMC_AC_READBACK_EN
   logic w_rise;
`endif

   assign w_shiftEn = (r_state == SHIFT);

   pmc_ac_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (w_shiftEn),
      .o_sclk   (w_sclk),
      .o_bitEnd (w_bitEnd)
`ifdef PMC_AC_READBACK_EN
      ,
      .o_rise   (w_rise)
`endif
   );

   always_comb begin
      w_stateNext    = r_state;
      w_shiftNext    = r_shift;
      w_bitCntNext   = r_bitCnt;
      w_latchCntNext = r_latchCnt;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_stateNext    = SHIFT;
               w_shiftNext    = i_ac;
               w_bitCntNext   = '0;
               w_latchCntNext = '0;
            end
         end
         SHIFT: begin
            if (w_bitEnd) begin
               w_shiftNext  = {r_shift[PMC_AC_BITS-2:0], 1'b0};
               w_bitCntNext = r_bitCnt + PMC_AC_CNT_W'(1);
               if (r_bitCnt == BIT_LAST) begin
                  w_stateNext = LATCH;
               end
            end
         end
         LATCH: begin
            if (r_latchCnt == LATCH_LAST) begin
               w_stateNext = DONE;
            end else begin
               w_latchCntNext = r_latchCnt + 8'd1;
            end
         end
         DONE: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase

      // Data only follows the shifter while shifting; the last bit stays on the pad through the latch
      w_sdoNext = r_sdo;
      if (w_stateNext == IDLE) begin
         w_sdoNext = 1'b0;
      end else if (w_stateNext == SHIFT) begin
         w_sdoNext = w_shiftNext[PMC_AC_BITS-1];
      end
   end

   // Pad-facing flags are decoded from the next state so every output leaves a flop
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bitCnt   <= '0;
         r_latchCnt <= '0;
         r_sdo      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_latch    <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_shift    <= w_shiftNext;
         r_bitCnt   <= w_bitCntNext;
         r_latchCnt <= w_latchCntNext;
         r_sdo      <= w_sdoNext;
         r_busy     <= (w_stateNext != IDLE);
         r_done     <= (w_stateNext == DONE);
         r_latch    <= (w_stateNext == LATCH);
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_ac_sclk  = w_sclk;
   assign o_ac_sdo   = r_sdo;
   assign o_ac_latch = r_latch;

`ifdef PMC_AC_READBACK_EN
   logic [PMC_AC_BITS-1:0] r_capture;
   pmc_ac_t                r_rdbk;
   logic                   r_rdbkValid;

   // Chain output is sampled on the first high cycle of each bit and enters at the LSB
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_capture   <= '0;
         r_rdbk      <= '0;
         r_rdbkValid <= 1'b0;
      end else begin
         if (w_rise) begin
            r_capture <= {r_capture[PMC_AC_BITS-2:0], i_ac_sdi};
         end
         if (w_stateNext == DONE) begin
            r_rdbk <= r_capture;
         end
         r_rdbkValid <= (w_stateNext == DONE);
      end
   end

   assign o_rdbk       = r_rdbk;
   assign o_rdbk_valid = r_rdbkValid;
`endif

endmodule

// File: tb/tb_pmc_ac_ctrl.sv
// Scoreboard bench for pmc_ac_ctrl: one instance at CLK_DIV=2, one at CLK_DIV=1.
// Readback checks are added when PMC_AC_READBACK_EN is defined.
module tb_pmc_ac_ctrl;

   localparam logic [127:0] PAT_A   = {32'hA5A5_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
   localparam logic [127:0] PAT_B   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
   localparam logic [127:0] PAT_C   = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
   localparam logic [127:0] PAT_D   = 128'h5555_AAAA_3333_CCCC_0F0F_F0F0_00FF_FF00;
   localparam logic [127:0] PAT_E   = 128'h8000_0000_0000_0001_F0F0_0F0F_1234_5678;
   localparam logic [127:0] PRELOAD = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

   typedef struct {
      logic [127:0] data;
      logic [127:0] rdbk;
      int           acceptCyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rstN;
   logic         start0, start1;
   logic [127:0] ac0, ac1;
   logic         busy0, done0, sclk0, sdo0, latch0;
   logic         busy1, done1, sclk1, sdo1, latch1;
   logic [127:0] chain;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1, eNew;

   int cyc = 0;
   int nChecks = 0;
   int nPass = 0;
   int nDone0 = 0;
   int nDone1 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef PMC_AC_READBACK_EN
   logic [127:0] rdbk0, rdbk1;
   logic         rdbkValid0, rdbkValid1;
   wire          sdi0 = chain[127];

   // Model of the matrix chain: shifts the pad data in on every falling serial clock
   always @(negedge sclk0) chain <= {chain[126:0], sdo0};
`endif

   pmc_ac_ctrl #(.CLK_DIV(2)) dut (
      .i_clk        (clk),
      .i_rst_n      (rstN),
      .i_start      (start0),
      .i_ac         (ac0),
      .o_busy       (busy0),
      .o_done       (done0),
      .o_ac_sclk    (sclk0),
      .o_ac_sdo     (sdo0),
      .o_ac_latch   (latch0)
`ifdef PMC_AC_READBACK_EN
      ,
      .i_ac_sdi     (sdi0),
      .o_rdbk       (rdbk0),
      .o_rdbk_valid (rdbkValid0)
`endif
   );

   pmc_ac_ctrl #(.CLK_DIV(1)) dut1 (
      .i_clk        (clk),
      .i_rst_n      (rstN),
      .i_start      (start1),
      .i_ac         (ac1),
      .o_busy       (busy1),
      .o_done       (done1),
      .o_ac_sclk    (sclk1),
      .o_ac_sdo     (sdo1),
      .o_ac_latch   (latch1)
`ifdef PMC_AC_READBACK_EN
      ,
      .i_ac_sdi     (1'b0),
      .o_rdbk       (rdbk1),
      .o_rdbk_valid (rdbkValid1)
`endif
   );

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
      nChecks++;
      if (act === req) nPass++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
   endtask

   task automatic checkCount(input string name, input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act === req) nPass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkCount({tag, "_busy"}, 32'(busy0), 0);
      checkCount({tag, "_done"}, 32'(done0), 0);
      checkCount({tag, "_sclk"}, 32'(sclk0), 0);
      checkCount({tag, "_sdo"}, 32'(sdo0), 0);
      checkCount({tag, "_latch"}, 32'(latch0), 0);
`ifdef PMC_AC_READBACK_EN
      checkOutput({tag, "_rdbk"}, rdbk0, '0);
      checkCount({tag, "_rdbk_valid"}, 32'(rdbkValid0), 0);
`endif
   endtask

   // Called just after a clock edge with the DUT idle; the current cycle is the accept cycle
   task automatic applyStimulus(input logic [127:0] val);
      ac0            = val;
      start0         = 1'b1;
      eNew.data      = val;
      eNew.rdbk      = chain;
      eNew.acceptCyc = cyc;
      q0.push_back(eNew);
      @(posedge clk);
      #1;
      start0 = 1'b0;
   endtask

   task automatic applyStimulusDiv1(input logic [127:0] val);
      ac1            = val;
      start1         = 1'b1;
      eNew.data      = val;
      eNew.rdbk      = '0;
      eNew.acceptCyc = cyc;
      q1.push_back(eNew);
      @(posedge clk);
      #1;
      start1 = 1'b0;
   endtask

   task automatic waitCycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulseStartBusy();
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
   endtask

   task automatic waitDone0(input int bound);
      int n = 0;
      while (!done0 && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkCount("done0_seen", 32'(done0), 1);
   endtask

   task automatic waitDone1(input int bound);
      int n = 0;
      while (!done1 && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkCount("done1_seen", 32'(done1), 1);
   endtask

   // Monitor for the CLK_DIV=2 instance: rebuilds the shifted word and timing, checks on done
   logic         prevBusy0 = 1'b0, prevSclk0 = 1'b0;
   int           busyStart0 = 0, rises0 = 0, latchCnt0 = 0, firstLatch0 = -1, latchBad0 = 0;
   logic [127:0] cap0 = '0;

   always @(negedge clk) begin
      if (busy0 && !prevBusy0) begin
         busyStart0  = cyc;
         rises0      = 0;
         latchCnt0   = 0;
         firstLatch0 = -1;
         latchBad0   = 0;
         cap0        = '0;
      end
      if (sclk0 && !prevSclk0) begin
         rises0++;
         cap0 = {cap0[126:0], sdo0};
      end
      if (latch0) begin
         if (firstLatch0 < 0) firstLatch0 = cyc;
         latchCnt0++;
         if (sclk0 !== 1'b0 || sdo0 !== cap0[0]) latchBad0++;
      end
      if (done0) begin
         nDone0++;
         checkCount("done0_expected", 32'(q0.size() != 0), 1);
         if (q0.size() != 0) begin
            e0 = q0.pop_front();
            checkOutput("shift_data", cap0, e0.data);
            checkCount("done_cycle", cyc - e0.acceptCyc, 515);
            checkCount("busy_start", busyStart0 - e0.acceptCyc, 1);
            checkCount("busy_len", cyc - busyStart0 + 1, 515);
            checkCount("sclk_rises", rises0, 128);
            checkCount("latch_len", latchCnt0, 2);
            checkCount("latch_start", firstLatch0 - e0.acceptCyc, 513);
            checkCount("latch_pads", latchBad0, 0);
`ifdef PMC_AC_READBACK_EN
            checkCount("rdbk_valid", 32'(rdbkValid0), 1);
            checkOutput("rdbk", rdbk0, e0.rdbk);
`endif
         end
      end
      prevBusy0 = busy0;
      prevSclk0 = sclk0;
   end

   // Monitor for the CLK_DIV=1 instance
   logic         prevBusy1 = 1'b0, prevSclk1 = 1'b0;
   int           busyStart1 = 0, rises1 = 0, latchCnt1 = 0, noToggle1 = 0;
   logic [127:0] cap1 = '0;

   always @(negedge clk) begin
      if (busy1 && !prevBusy1) begin
         busyStart1 = cyc;
         rises1     = 0;
         latchCnt1  = 0;
         noToggle1  = 0;
         cap1       = '0;
      end
      if (sclk1 && !prevSclk1) begin
         rises1++;
         cap1 = {cap1[126:0], sdo1};
      end
      if (busy1 && q1.size() > 0) begin
         if (cyc >= q1[0].acceptCyc + 2 && cyc <= q1[0].acceptCyc + 256 && sclk1 === prevSclk1) noToggle1++;
      end
      if (latch1) latchCnt1++;
      if (done1) begin
         nDone1++;
         checkCount("done1_expected", 32'(q1.size() != 0), 1);
         if (q1.size() != 0) begin
            e1 = q1.pop_front();
            checkOutput("div1_data", cap1, e1.data);
            checkCount("div1_busy_len", cyc - busyStart1 + 1, 258);
            checkCount("div1_busy_start", busyStart1 - e1.acceptCyc, 1);
            checkCount("div1_rises", rises1, 128);
            checkCount("div1_toggle_misses", noToggle1, 0);
            checkCount("div1_latch_len", latchCnt1, 1);
         end
      end
      prevBusy1 = busy1;
      prevSclk1 = sclk1;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", nPass, nChecks + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int acceptA;
      int acceptC;
      rstN   = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      ac0    = '0;
      ac1    = '0;
      chain  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("in_reset");
      rstN = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("idle");

      // Sequence A with late ac change and two ignored start pulses
      chain   = PRELOAD;
      acceptA = cyc;
      applyStimulus(PAT_A);
      waitCycle(acceptA + 2);
      ac0 = ~PAT_A;
      waitCycle(acceptA + 10);
      pulseStartBusy();
      waitCycle(acceptA + 300);
      pulseStartBusy();
      waitDone0(600);

      // Back-to-back start on the cycle after done
      @(posedge clk);
      #1;
      applyStimulus(PAT_B);
      waitDone0(600);

      // Sequence C aborted by reset mid-shift, then a clean sequence D
      @(posedge clk);
      #1;
      acceptC = cyc;
      applyStimulus(PAT_C);
      waitCycle(acceptC + 200);
      #2;
      rstN = 1'b0;
      #1;
      checkResetOutputs("mid_reset");
      q0.delete();
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(PAT_D);
      waitDone0(600);

      // CLK_DIV=1 instance
      repeat (3) @(posedge clk);
      #1;
      applyStimulusDiv1(PAT_E);
      waitDone1(300);

      repeat (20) @(posedge clk);
      #1;
      checkCount("done0_count", nDone0, 3);
      checkCount("done1_count", nDone1, 1);
      checkCount("queues_empty", q0.size() + q1.size(), 0);
      checkCount("final_busy", 32'(busy0), 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/pmc_ac_ctrl.md
# pmc_ac_ctrl

Serial loader for the pixel matrix analog configuration. On a start pulse it snapshots the 128-bit `pmc_ac_t` register set and shifts it into the matrix analog-configuration shift chain using a generated serial clock. It then pulses a latch strobe so the chain contents are transferred to the pixel DACs. It sits between the PMC analog-conf register bank (bus side) and the matrix pads.

## Interface
Parameters:
- `CLK_DIV`, default 2: system cycles per serial-clock half period; legal range 1..255.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle load request; sampled only in IDLE.
- `ac` in `pmc_ac_t` (128): configuration source; sampled on the cycle `start` is accepted.
- `busy` out 1: high from the cycle after acceptance through the DONE cycle.
- `done` out 1: one-cycle pulse at end of sequence.
- `ac_sclk` out 1: serial clock to the chain.
- `ac_sdo` out 1: serial data to the chain.
- `ac_latch` out 1: chain-to-DAC transfer strobe.
- `ac_sdi` in 1: chain serial output; present only with `PMC_AC_READBACK_EN`.
- `rdbk` out `pmc_ac_t` (128): captured previous chain contents; present only with `PMC_AC_READBACK_EN`.
- `rdbk_valid` out 1: one-cycle pulse coincident with `done`; present only with `PMC_AC_READBACK_EN`.

## Operation
- States are IDLE, SHIFT, LATCH and DONE.
- IDLE -> SHIFT when `start`=1.
  - Same cycle: `ac` is copied into a 128-bit shift register.
  - The bit counter and phase counter clear.
- SHIFT, per bit:
  - `ac_sdo` is driven with the shift-register MSB.
  - `ac_sclk` is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - At the end of the high phase, the shift register shifts left by 1 and the bit counter increments.
- Bit order: `ac[127]` (reg_0[31]) is sent first and `ac[0]` (reg_3[0]) last.
- SHIFT -> LATCH after bit counter value 127 completes its high phase. The 7-bit counter wraps to 0 at this point.
- LATCH: `ac_latch`=1 for CLK_DIV cycles; `ac_sclk`=0; `ac_sdo` holds the last bit.
- LATCH -> DONE. DONE: `done`=1 for one cycle, then the block returns to IDLE.
- `start` while busy is ignored; it is neither queued nor restarts the sequence.
- `ac` changes after acceptance have no effect on the current sequence.
- Reset values: `busy`, `done`, `ac_sclk`, `ac_sdo`, `ac_latch`, `rdbk_valid` = 0; `rdbk` = 0; state = IDLE.
- Reset mid-sequence:
  - All outputs go to reset values immediately (asynchronously).
  - No `done` pulse is produced; chain contents are undefined.
  - The next `start` after reset release is honoured normally.

## Timing
- `start` accepted at cycle 0. SHIFT begins at cycle 1.
- Bit n (0..127) occupies cycles 1+2·CLK_DIV·n through 2·CLK_DIV·(n+1).
- LATCH occupies the CLK_DIV cycles after the shift phase. DONE is the following cycle.
- Total `busy` duration = 256·CLK_DIV + CLK_DIV + 1 cycles.
- Example, CLK_DIV=2: `busy` is high for cycles 1..515, LATCH is 513..514, `done` is at 515, and a new `start` is accepted at 516.
- All outputs are registered: no combinational path from `start`/`ac` to pad outputs.

## Configuration
- `PMC_AC_READBACK_EN` defined:
  - `ac_sdi` is sampled on each cycle where `ac_sclk` rises (the first high cycle of each bit).
  - Each sample is shifted into a 128-bit capture register at its LSB.
  - At DONE, the capture register is copied to `rdbk` and `rdbk_valid` pulses.
  - `rdbk` holds its value until the next DONE.
- Not defined: the `ac_sdi`, `rdbk` and `rdbk_valid` ports and all capture logic are absent; shift behaviour is identical.

## Structure
- `pmc_ac_pkg` additions:
  - `pmc_ac_ctrl_state_t` enum (IDLE, SHIFT, LATCH, DONE).
  - `PMC_AC_BITS` = 128 constant.
  - Existing `pmc_ac_t` is reused as the data type.
- One sub-module, `pmc_ac_sclk_gen`:
  - Runs the phase counter and generates `ac_sclk`.
  - Outputs a rise tick and an end-of-bit tick.
  - Enabled only in SHIFT.

## Test plan
- Reset then idle with CLK_DIV=2: all outputs 0; `start` pulse → `busy` rises at cycle 1, `done` at cycle 515, exactly 128 `ac_sclk` rising edges.
- `ac` = {32'hA5A5_0001, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000}:
  - `ac_sdo` sampled at each `ac_sclk` rise reproduces all 128 bits, MSB first.
  - `ac_latch` is high for 2 cycles after the last fall.
- `start` pulsed at cycles 10 and 300 during a sequence: ignored, single `done`. `ac` changed at cycle 2: shifted data still equals the value snapshotted at cycle 0.
- `rst_n` asserted at cycle 200 mid-SHIFT:
  - Outputs are 0 within the reset cycle, with no `done`.
  - After release, a new `start` completes normally.
- CLK_DIV=1: `busy` lasts 258 cycles; `ac_sclk` toggles every cycle.
- With `PMC_AC_READBACK_EN` and `ac_sdi` fed by a 128-bit model chain preloaded with 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677: `rdbk` equals that value when `rdbk_valid`=1.
